inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32: width of the instruction word and the PC.
REQ-002 The block SHALL have parameter DEPTH, default 8: number of entries; power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1: fetch presents a word.
REQ-006 The block SHALL have port in_ready, output, 1: the queue can accept a word this cycle.
REQ-007 The block SHALL have port in_inst, input, WORD_SIZE: instruction word from fetch.
REQ-008 The block SHALL have port in_pc, input, WORD_SIZE: PC of in_inst.
REQ-009 The block SHALL have port out_valid, output, 1: the head entry is available to decode.
REQ-010 The block SHALL have port out_ready, input, 1: decode consumes the head this cycle.
REQ-011 The block SHALL have port out_inst, output, WORD_SIZE: head instruction word.
REQ-012 The block SHALL have port out_pc, output, WORD_SIZE: head PC.
REQ-013 The block SHALL have port flush, input, 1: discard all entries on a branch redirect.
REQ-014 The block SHALL have port count, output, log2(DEPTH)+1: number of occupied entries.

Function
REQ-015 The block SHALL be a circular FIFO using head and tail pointers of log2(DEPTH) bits each; both pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 The block SHALL drive in_ready = rst_n AND (count < DEPTH), derived only from registered state.
REQ-017 The block SHALL drive out_valid = (count != 0), derived only from registered state.
REQ-018 A push SHALL occur when in_valid AND in_ready AND NOT flush: {in_inst, in_pc} is written at the tail and the tail advances.
REQ-019 A pop SHALL occur when out_valid AND out_ready AND NOT flush: the head advances.
REQ-020 out_inst and out_pc SHALL show the head entry combinationally (first-word fall-through) while out_valid=1, and SHALL be 0 while out_valid=0.
REQ-021 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 Latency: a word pushed into an empty queue SHALL appear with out_valid=1 in the next cycle. There SHALL be no same-cycle bypass.
REQ-023 When the queue is full, in_ready SHALL be 0 even if a pop occurs in the same cycle. The freed slot SHALL become visible in the next cycle.
REQ-024 flush SHALL take priority over push and pop: on the next edge, count=0 and head=tail=0. Any same-cycle push or pop SHALL be discarded.
REQ-025 Entry order SHALL be strict FIFO. Stored data SHALL NOT change while an entry is occupied.
REQ-026 in_inst and in_pc SHALL be ignored when no push occurs.

Reset
REQ-027 While rst_n=0, regardless of clk: count=0, head=tail=0, out_valid=0, in_ready=0, out_inst=0, out_pc=0.
REQ-028 On the first rising clk edge after rst_n rises: in_ready=1, out_valid=0.
REQ-029 Storage contents SHALL NOT need reset. No pre-reset data SHALL be observable at out_inst or out_pc.
REQ-030 An assertion of rst_n mid-operation SHALL immediately empty the queue, identically to REQ-027.

Verification
REQ-031 Scenario basic push: after reset, push inst=0x00000013, pc=0x00000000 with out_ready=0. Next cycle: out_valid=1, out_inst=0x00000013, out_pc=0, count=1.
REQ-032 Scenario fill and wrap: push 8 words with pc 0x0..0x1C, out_ready=0. Then: count=8, in_ready=0. Pop 3, then push 3 more with pc 0x20..0x28. Required: pop order 0x0C..0x28, and tail wraps past 7 with no data loss.
REQ-033 Scenario full with simultaneous pop: with count=8, in_valid=1 and out_ready=1 in the same cycle. Required: the pop occurs, the push is refused, count=7, and in_ready=1 in the next cycle.
REQ-034 Scenario steady stream: in_valid=1 and out_ready=1 continuously from empty. Required: count settles at 1 and one word exits per cycle, in order, one cycle after entry.
REQ-035 Scenario flush: with count=5, assert flush together with in_valid=1 and out_ready=1. Next cycle: count=0, out_valid=0, out_inst=0. A subsequent push appears at out_pc unchanged.
REQ-036 Scenario async reset: with count=4, pull rst_n low between clk edges. Required: out_valid=0, in_ready=0 and count=0 before the next edge.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO with first-word fall-through head.
// Latency: a word pushed into an empty queue is visible at out_* on the next cycle (no bypass).
// Backpressure: in_ready drops when full (a same-cycle pop does not reopen it); flush empties the queue.
module inst_queue #(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_SIZE-1:0]   in_inst,
    input  logic [WORD_SIZE-1:0]   in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_SIZE-1:0]   out_inst,
    output logic [WORD_SIZE-1:0]   out_pc,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [WORD_SIZE-1:0] inst;
        logic [WORD_SIZE-1:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head_dat;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;

    // Flow control comes only from registered occupancy, never from same-cycle pops.
    assign in_ready  = rst_n & (count < FULL);
    assign out_valid = (count != '0);

    // flush wins over both handshakes; the discarded transfers leave no trace.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Head is gated to zero when empty so stale or never-written storage cannot leak out.
    assign head_dat = mem[head];
    assign out_inst = out_valid ? head_dat.inst : '0;
    assign out_pc   = out_valid ? head_dat.pc   : '0;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is written only on an accepted push; it needs no reset because reads are gated.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{inst: in_inst, pc: in_pc};
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_inst = '0;
    logic [W-1:0] in_pc = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_inst;
    logic [W-1:0] out_pc;
    logic         flush = 1'b0;
    logic [3:0]   count;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of {inst, pc} in arrival order.
    logic [2*W-1:0] sb[$];
    bit             model_rdy = 1'b0;

    inst_queue #(.WORD_SIZE(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model update on the clock: accepted pushes enter the queue, flush/reset empty it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    sb.delete();
        else if (flush)                sb.delete();
        else if (in_valid && model_rdy) sb.push_back({in_inst, in_pc});
    end

    // Monitor on the falling edge: compare DUT outputs with the model, then retire a pop.
    always @(negedge clk) begin
        bit exp_v;
        exp_v = (sb.size() != 0);
        chk("count", 64'(count), 64'(sb.size()));
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        model_rdy = rst_n && (sb.size() < DEPTH);
        chk("in_ready", 64'(in_ready), 64'(model_rdy));
        if (exp_v) begin
            chk("out_inst", 64'(out_inst), 64'(sb[0][2*W-1:W]));
            chk("out_pc", 64'(out_pc), 64'(sb[0][W-1:0]));
        end else begin
            chk("out_inst_zero", 64'(out_inst), 64'd0);
            chk("out_pc_zero", 64'(out_pc), 64'd0);
        end
        if (exp_v && out_ready && !flush) void'(sb.pop_front());
    end

    // One cycle of stimulus; data is randomised when not valid to show it is ignored.
    task automatic drive(input bit iv, input logic [W-1:0] ins, input logic [W-1:0] p,
                         input bit ordy, input bit fl);
        in_valid  = iv;
        in_inst   = iv ? ins : $urandom;
        in_pc     = iv ? p   : $urandom;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        #1;
        do_reset();

        // Basic push, observe, pop.
        drive(1, 32'h0000_0013, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);

        // Fill to full, attempt an extra push, pop 3, refill 3 across the wrap.
        for (int i = 0; i < 8; i++) drive(1, $urandom, 32'(i * 4), 0, 0);
        drive(1, 32'hdead_beef, 32'h100, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, $urandom, 32'(32'h20 + i * 4), 0, 0);

        // Full with simultaneous pop: pop occurs, push refused.
        drive(1, 32'hbad0_0001, 32'h200, 1, 0);
        drive(0, 0, 0, 0, 0);

        // Drain, then flush with count=5 against push and pop.
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, $urandom, 32'(32'h300 + i * 4), 0, 0);
        drive(1, 32'hbad0_0002, 32'h400, 1, 1);
        drive(0, 0, 0, 0, 0);
        drive(1, 32'h0000_1111, 32'h0000_1234, 0, 0);
        drive(0, 0, 0, 1, 0);

        // Steady stream from empty.
        for (int i = 0; i < 20; i++) drive(1, $urandom, 32'(32'h500 + i * 4), 1, 0);
        drive(0, 0, 0, 1, 0);

        // Asynchronous reset between edges with count=4.
        for (int i = 0; i < 4; i++) drive(1, $urandom, 32'(32'h600 + i * 4), 0, 0);
        #2;
        do_reset();

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
